// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Central stall/flush sequencer for the 5-stage pipeline. It drives the hold
// and clear controls of the PC, IF/ID, ID/EX and EX/MEM registers and handles:
//   - startup bubbles after reset (IF/ID forced to NOP for STARTUP_BUBBLES)
//   - load-use stalls (one-cycle bubble inserted into EX)
//   - taken-branch flushes resolved in EX
//   - multi-cycle data-memory waits, with a timeout that raises mem_err
//
// All controls are combinational from the current state and inputs.
//
// Parameters:
//   STARTUP_BUBBLES  cycles after reset that IF/ID is forced to NOP (1..15)
//   TMO_W            memory-wait timeout counter width (>= 2); the wait is
//                    abandoned after 2**TMO_W-1 stalled cycles
//   PERF_W           performance counter width (HAZ_PERF_CNT_EN builds only)
//
// Optional feature macro: HAZ_PERF_CNT_EN
//   When defined, adds saturating stall_cnt / flush_cnt outputs.
//
// Ports:
//   clk, rst_n             clock (rising edge), async active-low reset
//   id_rs1/id_rs2 (+_used) source registers of the instruction in ID
//   ex_rd, ex_mem_read     destination / load flag of the instruction in EX
//   ex_branch_taken        branch/jump resolved taken in EX this cycle
//   mem_req, mem_ready     MEM-stage access active / completing this cycle
//   pc_stall, ifid_stall, idex_stall, exmem_stall   hold controls
//   ifid_flush, idex_flush load NOP (overrides the matching stall)
//   startup_busy           high while in INIT
//   mem_err                sticky memory-wait timeout flag
//   state_o                current state encoding (debug)
//   stall_cnt, flush_cnt   performance counters (HAZ_PERF_CNT_EN only)
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int STARTUP_BUBBLES = 1,
  parameter int TMO_W           = 8
`ifdef HAZ_PERF_CNT_EN
  ,
  parameter int PERF_W          = 32
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [4:0]        ex_rd,
  input  logic              ex_mem_read,
  input  logic              ex_branch_taken,
  input  logic              mem_req,
  input  logic              mem_ready,
  output logic              pc_stall,
  output logic              ifid_stall,
  output logic              ifid_flush,
  output logic              idex_stall,
  output logic              idex_flush,
  output logic              exmem_stall,
  output logic              startup_busy,
  output logic              mem_err,
  output logic [2:0]        state_o
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0] stall_cnt,
  output logic [PERF_W-1:0] flush_cnt
`endif
);

  typedef enum logic [2:0] {
    S_INIT     = 3'd0,
    S_RUN      = 3'd1,
    S_MEM_WAIT = 3'd2
  } state_e;

  // Value of tmo_q on the last stalled wait cycle: the increment that would
  // reach 2**TMO_W-1 is replaced by the timeout instead.
  localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};
  localparam logic [3:0]       BUBBLE_LAST = 4'(STARTUP_BUBBLES - 1);

  state_e           state_q, state_d;
  logic [3:0]       bubble_q, bubble_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             mem_err_q, mem_err_d;

  logic             load_use_hz;
  logic             run_prio;   // apply the branch / load-use priorities this cycle

  // ex_rd == x0 never creates a dependency.
  assign load_use_hz = ex_mem_read && (ex_rd != 5'd0) &&
                       ((id_rs1_used && (id_rs1 == ex_rd)) ||
                        (id_rs2_used && (id_rs2 == ex_rd)));

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    bubble_d     = bubble_q;
    tmo_d        = tmo_q;
    mem_err_d    = mem_err_q;
    run_prio     = 1'b0;
    pc_stall     = 1'b0;
    ifid_stall   = 1'b0;
    ifid_flush   = 1'b0;
    idex_stall   = 1'b0;
    idex_flush   = 1'b0;
    exmem_stall  = 1'b0;
    startup_busy = 1'b0;

    unique case (state_q)
      S_INIT: begin
        // PC keeps fetching while IF/ID is forced to NOP; other inputs ignored.
        ifid_flush   = 1'b1;
        startup_busy = 1'b1;
        bubble_d     = bubble_q + 4'd1;
        if (bubble_q == BUBBLE_LAST) begin
          state_d  = S_RUN;
          bubble_d = 4'd0;
        end
      end

      S_RUN: begin
        if (mem_req && !mem_ready) begin
          pc_stall    = 1'b1;
          ifid_stall  = 1'b1;
          idex_stall  = 1'b1;
          exmem_stall = 1'b1;
          state_d     = S_MEM_WAIT;
          tmo_d       = TMO_W'(1);
        end else begin
          run_prio = 1'b1;
        end
      end

      S_MEM_WAIT: begin
        if (!mem_ready) begin
          pc_stall    = 1'b1;
          ifid_stall  = 1'b1;
          idex_stall  = 1'b1;
          exmem_stall = 1'b1;
          if (tmo_q == TMO_LAST) begin
            // Give up on the access: flag it and release the pipeline.
            mem_err_d = 1'b1;
            state_d   = S_RUN;
            tmo_d     = '0;
          end else begin
            tmo_d = tmo_q + TMO_W'(1);
          end
        end else begin
          // Access done: a branch held in EX during the wait resolves now.
          run_prio = 1'b1;
          state_d  = S_RUN;
          tmo_d    = '0;
        end
      end

      default: begin
        state_d = S_INIT;
      end
    endcase

    // A taken branch kills the ID instruction, so it outranks load-use.
    if (run_prio) begin
      if (ex_branch_taken) begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (load_use_hz) begin
        pc_stall   = 1'b1;
        ifid_stall = 1'b1;
        idex_flush = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_INIT;
      bubble_q  <= 4'd0;
      tmo_q     <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bubble_q  <= bubble_d;
      tmo_q     <= tmo_d;
      mem_err_q <= mem_err_d;
    end
  end

  assign mem_err = mem_err_q;
  assign state_o = state_q;

`ifdef HAZ_PERF_CNT_EN
  logic [PERF_W-1:0] stall_cnt_q;
  logic [PERF_W-1:0] flush_cnt_q;

  // Saturating counters: they stick at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (pc_stall && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + PERF_W'(1);
      end
      if (idex_flush && (state_q != S_INIT) && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + PERF_W'(1);
      end
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  // Performance counters not built: no stall_cnt / flush_cnt ports or logic.
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//
// Self-checking bench for pipe_hazard_ctrl (STARTUP_BUBBLES=2, TMO_W=3).
// Directed scenario tasks check against constant control patterns; a random
// phase checks every cycle against a behavioural model built from the
// hazard rules (startup bubble count, wait-cycle count up to the limit).
// Builds with or without HAZ_PERF_CNT_EN.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

  localparam int SB    = 2;
  localparam int TW    = 3;
  localparam int LIMIT = 7;   // stalled wait cycles before timeout (2**TW-1)
`ifdef HAZ_PERF_CNT_EN
  localparam int PW    = 32;
`endif

  // {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall, startup_busy}
  localparam logic [6:0] C_NONE = 7'b0000000;
  localparam logic [6:0] C_INIT = 7'b0010001;
  localparam logic [6:0] C_LU   = 7'b1100100;
  localparam logic [6:0] C_BR   = 7'b0010100;
  localparam logic [6:0] C_MW   = 7'b1101010;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_rs1_used, id_rs2_used, ex_mem_read, ex_branch_taken;
  logic       mem_req, mem_ready;
  logic       pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush;
  logic       exmem_stall, startup_busy, mem_err;
  logic [2:0] state_o;
`ifdef HAZ_PERF_CNT_EN
  logic [PW-1:0] stall_cnt, flush_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(
    .STARTUP_BUBBLES(SB),
    .TMO_W          (TW)
`ifdef HAZ_PERF_CNT_EN
    ,
    .PERF_W         (PW)
`endif
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .id_rs1_used    (id_rs1_used),
    .id_rs2_used    (id_rs2_used),
    .ex_rd          (ex_rd),
    .ex_mem_read    (ex_mem_read),
    .ex_branch_taken(ex_branch_taken),
    .mem_req        (mem_req),
    .mem_ready      (mem_ready),
    .pc_stall       (pc_stall),
    .ifid_stall     (ifid_stall),
    .ifid_flush     (ifid_flush),
    .idex_stall     (idex_stall),
    .idex_flush     (idex_flush),
    .exmem_stall    (exmem_stall),
    .startup_busy   (startup_busy),
    .mem_err        (mem_err),
    .state_o        (state_o)
`ifdef HAZ_PERF_CNT_EN
    ,
    .stall_cnt      (stall_cnt),
    .flush_cnt      (flush_cnt)
`endif
  );

  function automatic logic [6:0] ctl();
    return {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall, startup_busy};
  endfunction

  task automatic set_idle();
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
    id_rs1_used = 1'b0; id_rs2_used = 1'b0;
    ex_mem_read = 1'b0; ex_branch_taken = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Reset asserted asynchronously, released on a falling edge.
  task automatic test_reset();
    set_idle();
    rst_n = 1'b0;
    #1;
    n_vec++; if (ctl() !== C_INIT) begin n_err++; $display("FAIL reset_ctl: got %b want %b", ctl(), C_INIT); end
    n_vec++; if (state_o !== 3'd0) begin n_err++; $display("FAIL reset_state: got %0d want 0", state_o); end
    n_vec++; if (mem_err !== 1'b0) begin n_err++; $display("FAIL reset_mem_err: got %b want 0", mem_err); end
`ifdef HAZ_PERF_CNT_EN
    n_vec++; if (stall_cnt !== '0 || flush_cnt !== '0) begin n_err++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", stall_cnt, flush_cnt); end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  // Two INIT cycles with ifid_flush, then RUN.
  task automatic test_startup();
    n_vec++; if (ctl() !== C_INIT) begin n_err++; $display("FAIL startup_c1: got %b want %b", ctl(), C_INIT); end
    next_cycle();
    n_vec++; if (ctl() !== C_INIT || state_o !== 3'd0) begin n_err++; $display("FAIL startup_c2: got %b/%0d want %b/0", ctl(), state_o, C_INIT); end
    next_cycle();
    n_vec++; if (ctl() !== C_NONE || state_o !== 3'd1) begin n_err++; $display("FAIL startup_run: got %b/%0d want %b/1", ctl(), state_o, C_NONE); end
  endtask

  task automatic test_load_use();
    set_idle();
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_rs2_used = 1'b1;
    #1;
    n_vec++; if (ctl() !== C_LU) begin n_err++; $display("FAIL lu_rs2: got %b want %b", ctl(), C_LU); end
    next_cycle();
    ex_mem_read = 1'b0;   // bubble now in EX
    #1;
    n_vec++; if (ctl() !== C_NONE || state_o !== 3'd1) begin n_err++; $display("FAIL lu_release: got %b/%0d want %b/1", ctl(), state_o, C_NONE); end
    next_cycle();
    ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs2 = 5'd0;
    #1;
    n_vec++; if (ctl() !== C_NONE) begin n_err++; $display("FAIL lu_x0: got %b want %b", ctl(), C_NONE); end
    next_cycle();
    set_idle();
    ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7; id_rs1_used = 1'b1;
    #1;
    n_vec++; if (ctl() !== C_LU) begin n_err++; $display("FAIL lu_rs1: got %b want %b", ctl(), C_LU); end
    id_rs1_used = 1'b0;
    #1;
    n_vec++; if (ctl() !== C_NONE) begin n_err++; $display("FAIL lu_unused: got %b want %b", ctl(), C_NONE); end
    next_cycle();
    set_idle();
  endtask

  task automatic test_branch_over_load_use();
    set_idle();
    ex_branch_taken = 1'b1;
    ex_mem_read = 1'b1; ex_rd = 5'd9; id_rs1 = 5'd9; id_rs1_used = 1'b1;
    #1;
    n_vec++; if (ctl() !== C_BR) begin n_err++; $display("FAIL branch_lu: got %b want %b", ctl(), C_BR); end
    next_cycle();
    set_idle();
    #1;
    n_vec++; if (ctl() !== C_NONE || state_o !== 3'd1) begin n_err++; $display("FAIL branch_after: got %b/%0d want %b/1", ctl(), state_o, C_NONE); end
  endtask

  task automatic test_mem_wait();
    set_idle();
    mem_req = 1'b1; mem_ready = 1'b1;
    #1;
    n_vec++; if (ctl() !== C_NONE) begin n_err++; $display("FAIL mem_fast: got %b want %b", ctl(), C_NONE); end
    next_cycle();
    n_vec++; if (state_o !== 3'd1) begin n_err++; $display("FAIL mem_fast_state: got %0d want 1", state_o); end
    mem_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      #1;
      n_vec++; if (ctl() !== C_MW) begin n_err++; $display("FAIL mem_wait_c%0d: got %b want %b", i, ctl(), C_MW); end
      next_cycle();
      n_vec++; if (state_o !== 3'd2) begin n_err++; $display("FAIL mem_wait_state_c%0d: got %0d want 2", i, state_o); end
    end
    mem_ready = 1'b1;
    #1;
    n_vec++; if (ctl() !== C_NONE) begin n_err++; $display("FAIL mem_done: got %b want %b", ctl(), C_NONE); end
    next_cycle();
    n_vec++; if (state_o !== 3'd1 || mem_err !== 1'b0) begin n_err++; $display("FAIL mem_done_state: got %0d/%b want 1/0", state_o, mem_err); end
    // Branch held in EX during a wait flushes when the data arrives.
    mem_ready = 1'b0;
    next_cycle();
    ex_branch_taken = 1'b1;
    #1;
    n_vec++; if (ctl() !== C_MW) begin n_err++; $display("FAIL mem_branch_wait: got %b want %b", ctl(), C_MW); end
    mem_ready = 1'b1;
    #1;
    n_vec++; if (ctl() !== C_BR) begin n_err++; $display("FAIL mem_branch_done: got %b want %b", ctl(), C_BR); end
    next_cycle();
    set_idle();
  endtask

  task automatic test_timeout();
    set_idle();
    mem_req = 1'b1;
    for (int i = 1; i <= LIMIT; i++) begin
      #1;
      n_vec++; if (ctl() !== C_MW || mem_err !== 1'b0) begin n_err++; $display("FAIL tmo_wait_c%0d: got %b/%b want %b/0", i, ctl(), mem_err, C_MW); end
      next_cycle();
    end
    n_vec++; if (mem_err !== 1'b1 || state_o !== 3'd1) begin n_err++; $display("FAIL tmo_err: got %b/%0d want 1/1", mem_err, state_o); end
    mem_req = 1'b0;
    #1;
    n_vec++; if (ctl() !== C_NONE) begin n_err++; $display("FAIL tmo_release: got %b want %b", ctl(), C_NONE); end
    next_cycle();
    n_vec++; if (mem_err !== 1'b1) begin n_err++; $display("FAIL tmo_sticky: got %b want 1", mem_err); end
  endtask

  task automatic test_reset_mid_wait();
    set_idle();
    mem_req = 1'b1;
    next_cycle();
    n_vec++; if (state_o !== 3'd2) begin n_err++; $display("FAIL rmw_enter: got %0d want 2", state_o); end
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++; if (ctl() !== C_INIT || state_o !== 3'd0 || mem_err !== 1'b0) begin n_err++; $display("FAIL rmw_reset: got %b/%0d/%b want %b/0/0", ctl(), state_o, mem_err, C_INIT); end
`ifdef HAZ_PERF_CNT_EN
    n_vec++; if (stall_cnt !== '0 || flush_cnt !== '0) begin n_err++; $display("FAIL rmw_cnt: got %0d/%0d want 0/0", stall_cnt, flush_cnt); end
`endif
    set_idle();
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();
    next_cycle();
    n_vec++; if (state_o !== 3'd1) begin n_err++; $display("FAIL rmw_restart: got %0d want 1", state_o); end
  endtask

  // Random stimulus against a rule-level model of the controller.
  task automatic test_random();
    int          mode;     // 0 startup, 1 running, 2 waiting on memory
    int          boot;     // startup cycles elapsed
    int          waited;   // stalled cycles spent on the current access
    logic        m_err;
    logic [6:0]  exp;
    logic        hazard;
    logic [31:0] m_stall, m_flush;

    set_idle();
    rst_n = 1'b0;
    #1;
    @(negedge clk);
    rst_n = 1'b1;
    mode = 0; boot = 0; waited = 0; m_err = 1'b0; m_stall = '0; m_flush = '0;

    for (int n = 0; n < 1500; n++) begin
      id_rs1          = 5'($urandom_range(0, 3));
      id_rs2          = 5'($urandom_range(0, 3));
      ex_rd           = 5'($urandom_range(0, 3));
      id_rs1_used     = 1'($urandom_range(0, 1));
      id_rs2_used     = 1'($urandom_range(0, 1));
      ex_mem_read     = 1'($urandom_range(0, 1));
      ex_branch_taken = ($urandom_range(0, 7) == 0);
      mem_req         = ($urandom_range(0, 3) == 0);
      mem_ready       = ($urandom_range(0, 3) == 0);
      #1;

      hazard = ex_mem_read && ex_rd != 0 &&
               ((id_rs1_used && id_rs1 == ex_rd) || (id_rs2_used && id_rs2 == ex_rd));
      if (mode == 0)                             exp = C_INIT;
      else if (mode == 1 && mem_req && !mem_ready) exp = C_MW;
      else if (mode == 2 && !mem_ready)          exp = C_MW;
      else if (ex_branch_taken)                  exp = C_BR;
      else if (hazard)                           exp = C_LU;
      else                                       exp = C_NONE;

      n_vec++; if (ctl() !== exp) begin n_err++; $display("FAIL rnd_ctl[%0d]: got %b want %b", n, ctl(), exp); end
      n_vec++; if (state_o !== 3'(mode) || mem_err !== m_err) begin n_err++; $display("FAIL rnd_state[%0d]: got %0d/%b want %0d/%b", n, state_o, mem_err, mode, m_err); end
`ifdef HAZ_PERF_CNT_EN
      n_vec++; if (stall_cnt !== m_stall || flush_cnt !== m_flush) begin n_err++; $display("FAIL rnd_cnt[%0d]: got %0d/%0d want %0d/%0d", n, stall_cnt, flush_cnt, m_stall, m_flush); end
`endif
      if (exp[6]) m_stall++;
      if (exp[2]) m_flush++;

      @(posedge clk);
      #1;
      case (mode)
        0: begin
          boot++;
          if (boot == SB) mode = 1;
        end
        1: begin
          if (mem_req && !mem_ready) begin
            mode   = 2;
            waited = 1;
          end
        end
        default: begin
          if (mem_ready) begin
            mode = 1;
          end else begin
            waited++;
            if (waited == LIMIT) begin
              m_err = 1'b1;
              mode  = 1;
            end
          end
        end
      endcase
    end
    set_idle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_startup();
    test_load_use();
    test_branch_over_load_use();
    test_mem_wait();
    test_timeout();
    test_reset_mid_wait();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
